// File: rtl/regex_memory_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// regex_memory_arbiter: shares one instruction BRAM between round-robin CPU fetches
// and host program-load writes.                                     Rev 1.0
// ----------------------------------------------------------------------------
module regex_memory_arbiter #(
  parameter int CPU_COUNT         = 4,
  parameter int CPU_ID_BITS       = 2,
  parameter int MEMORY_WIDTH      = 20,
  parameter int MEMORY_ADDR_WIDTH = 11
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [CPU_COUNT-1:0]                   cpu_memory_valid,
  input  logic [CPU_COUNT*MEMORY_ADDR_WIDTH-1:0] cpu_memory_addr,
  output logic [CPU_COUNT-1:0]                   cpu_memory_ready,
  output logic [MEMORY_WIDTH-1:0]                cpu_memory_data,
  input  logic                                   host_write_valid,
  input  logic [MEMORY_ADDR_WIDTH-1:0]           host_write_addr,
  input  logic [MEMORY_WIDTH-1:0]                host_write_data,
  output logic                                   host_write_ready,
  output logic                                   bram_en,
  output logic                                   bram_we,
  output logic [MEMORY_ADDR_WIDTH-1:0]           bram_addr,
  output logic [MEMORY_WIDTH-1:0]                bram_wdata,
  input  logic [MEMORY_WIDTH-1:0]                bram_rdata,
  output logic [CPU_ID_BITS-1:0]                 grant_id,
  output logic                                   busy
);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_WRITE      = 3'd1;
  localparam logic [2:0] S_READ_ISSUE = 3'd2;
  localparam logic [2:0] S_READ_WAIT  = 3'd3;
  localparam logic [2:0] S_RESPOND    = 3'd4;

  logic [2:0]                   state_q, state_d;
  logic [CPU_ID_BITS-1:0]       rr_pointer_q, rr_pointer_d;
  logic                         host_last_q, host_last_d;
  logic [CPU_COUNT-1:0]         cpu_memory_ready_q, cpu_memory_ready_d;
  logic [MEMORY_WIDTH-1:0]      cpu_memory_data_q, cpu_memory_data_d;
  logic                         host_write_ready_q, host_write_ready_d;
  logic                         bram_en_q, bram_en_d;
  logic                         bram_we_q, bram_we_d;
  logic [MEMORY_ADDR_WIDTH-1:0] bram_addr_q, bram_addr_d;
  logic [MEMORY_WIDTH-1:0]      bram_wdata_q, bram_wdata_d;
  logic [CPU_ID_BITS-1:0]       grant_id_q, grant_id_d;
  logic                         busy_q, busy_d;

  logic [MEMORY_ADDR_WIDTH-1:0] cpu_addr [CPU_COUNT];
  logic [CPU_ID_BITS-1:0]       arb_ptr;
  logic                         arb_host_last;
  logic [CPU_ID_BITS-1:0]       cand_id;
  logic [CPU_ID_BITS-1:0]       win_id;
  logic                         win_found;
  logic                         decide;
  logic                         take_write;
  logic                         take_read;

  generate
    for (genvar i = 0; i < CPU_COUNT; i++) begin : g_addr_unpack
      assign cpu_addr[i] = cpu_memory_addr[i*MEMORY_ADDR_WIDTH +: MEMORY_ADDR_WIDTH];
    end
  endgenerate

  // RESPOND arbitrates as if already back in IDLE, using the pointer and
  // host_last values it is about to commit; this sustains one fetch per 3 cycles.
  assign decide        = (state_q == S_IDLE) || (state_q == S_RESPOND);
  assign arb_ptr       = (state_q == S_RESPOND) ? grant_id_q + CPU_ID_BITS'(1) : rr_pointer_q;
  assign arb_host_last = (state_q == S_RESPOND) ? 1'b0 : host_last_q;

  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    cand_id   = '0;
    for (int off = 0; off < CPU_COUNT; off++) begin
      cand_id = arb_ptr + CPU_ID_BITS'(off);
      if (!win_found && cpu_memory_valid[cand_id]) begin
        win_found = 1'b1;
        win_id    = cand_id;
      end
    end
  end

  assign take_write = host_write_valid && (!arb_host_last || !win_found);
  assign take_read  = !take_write && win_found;

  always_comb begin
    state_d            = state_q;
    rr_pointer_d       = rr_pointer_q;
    host_last_d        = host_last_q;
    cpu_memory_ready_d = '0;
    cpu_memory_data_d  = cpu_memory_data_q;
    host_write_ready_d = 1'b0;
    bram_en_d          = 1'b0;
    bram_we_d          = 1'b0;
    bram_addr_d        = bram_addr_q;
    bram_wdata_d       = bram_wdata_q;
    grant_id_d         = grant_id_q;

    case (state_q)
      S_WRITE: begin
        host_write_ready_d = 1'b1;
        host_last_d        = 1'b1;
        state_d            = S_IDLE;
      end
      S_READ_ISSUE: begin
        state_d = S_READ_WAIT;
      end
      S_READ_WAIT: begin
        cpu_memory_data_d              = bram_rdata;
        cpu_memory_ready_d[grant_id_q] = 1'b1;
        state_d                        = S_RESPOND;
      end
      S_RESPOND: begin
        rr_pointer_d = grant_id_q + CPU_ID_BITS'(1);
        host_last_d  = 1'b0;
        state_d      = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (decide) begin
      if (take_write) begin
        state_d      = S_WRITE;
        bram_en_d    = 1'b1;
        bram_we_d    = 1'b1;
        bram_addr_d  = host_write_addr;
        bram_wdata_d = host_write_data;
      end else if (take_read) begin
        state_d     = S_READ_ISSUE;
        bram_en_d   = 1'b1;
        bram_addr_d = cpu_addr[win_id];
        grant_id_d  = win_id;
      end
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q            <= S_IDLE;
      rr_pointer_q       <= '0;
      host_last_q        <= 1'b0;
      cpu_memory_ready_q <= '0;
      cpu_memory_data_q  <= '0;
      host_write_ready_q <= 1'b0;
      bram_en_q          <= 1'b0;
      bram_we_q          <= 1'b0;
      bram_addr_q        <= '0;
      bram_wdata_q       <= '0;
      grant_id_q         <= '0;
      busy_q             <= 1'b0;
    end else begin
      state_q            <= state_d;
      rr_pointer_q       <= rr_pointer_d;
      host_last_q        <= host_last_d;
      cpu_memory_ready_q <= cpu_memory_ready_d;
      cpu_memory_data_q  <= cpu_memory_data_d;
      host_write_ready_q <= host_write_ready_d;
      bram_en_q          <= bram_en_d;
      bram_we_q          <= bram_we_d;
      bram_addr_q        <= bram_addr_d;
      bram_wdata_q       <= bram_wdata_d;
      grant_id_q         <= grant_id_d;
      busy_q             <= busy_d;
    end
  end

  assign cpu_memory_ready = cpu_memory_ready_q;
  assign cpu_memory_data  = cpu_memory_data_q;
  assign host_write_ready = host_write_ready_q;
  assign bram_en          = bram_en_q;
  assign bram_we          = bram_we_q;
  assign bram_addr        = bram_addr_q;
  assign bram_wdata       = bram_wdata_q;
  assign grant_id         = grant_id_q;
  assign busy             = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_regex_memory_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_regex_memory_arbiter: directed self-checking bench for regex_memory_arbiter
// with a behavioural 1-cycle-latency BRAM.                          Rev 1.0
// ----------------------------------------------------------------------------
module tb_regex_memory_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  cpu_memory_valid = '0;
  logic [43:0] cpu_memory_addr = '0;
  logic [3:0]  cpu_memory_ready;
  logic [19:0] cpu_memory_data;
  logic        host_write_valid = 1'b0;
  logic [10:0] host_write_addr = '0;
  logic [19:0] host_write_data = '0;
  logic        host_write_ready;
  logic        bram_en;
  logic        bram_we;
  logic [10:0] bram_addr;
  logic [19:0] bram_wdata;
  logic [19:0] bram_rdata;
  logic [1:0]  grant_id;
  logic        busy;

  int errors = 0;
  int checks = 0;

  logic [19:0] mem [0:2047];

  regex_memory_arbiter #(
    .CPU_COUNT(4), .CPU_ID_BITS(2), .MEMORY_WIDTH(20), .MEMORY_ADDR_WIDTH(11)
  ) dut (
    .clk(clk), .rst(rst),
    .cpu_memory_valid(cpu_memory_valid), .cpu_memory_addr(cpu_memory_addr),
    .cpu_memory_ready(cpu_memory_ready), .cpu_memory_data(cpu_memory_data),
    .host_write_valid(host_write_valid), .host_write_addr(host_write_addr),
    .host_write_data(host_write_data), .host_write_ready(host_write_ready),
    .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
    .bram_wdata(bram_wdata), .bram_rdata(bram_rdata),
    .grant_id(grant_id), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 20'h0;
    mem[11'h0DC] = 20'h30041;
    mem[11'h011] = 20'h11111;
    mem[11'h122] = 20'h22222;
    mem[11'h233] = 20'h33333;
    mem[11'h344] = 20'h44444;
    mem[11'h010] = 20'hABCDE;
    mem[11'h020] = 20'h12345;
    mem[11'h055] = 20'h55555;
    mem[11'h066] = 20'h66666;
    mem[11'h077] = 20'h77777;
    mem[11'h088] = 20'h88888;
    mem[11'h100] = 20'h0BAD0;
  end

  always @(posedge clk) begin
    if (bram_en) begin
      if (bram_we) mem[bram_addr] <= bram_wdata;
      else         bram_rdata     <= mem[bram_addr];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cpu(input int id, input logic v, input logic [10:0] a);
    cpu_memory_valid[id]         = v;
    cpu_memory_addr[id*11 +: 11] = a;
  endtask

  task automatic do_reset();
    cpu_memory_valid = '0;
    cpu_memory_addr  = '0;
    host_write_valid = 1'b0;
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    #1 rst = 1'b0;
    tick();
    tick();
    checks++;
    if ({cpu_memory_ready, host_write_ready, bram_en, bram_we, busy} !== 8'h00) begin
      errors++;
      $display("FAIL reset_ctrl: got %h expected 00",
               {cpu_memory_ready, host_write_ready, bram_en, bram_we, busy});
    end
    checks++;
    if ({cpu_memory_data, bram_addr, bram_wdata, grant_id} !== 53'h0) begin
      errors++;
      $display("FAIL reset_data: got %h expected 0",
               {cpu_memory_data, bram_addr, bram_wdata, grant_id});
    end
    rst = 1'b1;
    tick();
    checks++;
    if ({busy, bram_en} !== 2'b00) begin
      errors++;
      $display("FAIL reset_release_idle: got %b expected 00", {busy, bram_en});
    end
  endtask

  task automatic test_single_fetch();
    set_cpu(2, 1'b1, 11'h0DC);
    tick();
    checks++;
    if ({grant_id, bram_en, bram_we, bram_addr, busy, cpu_memory_ready} !== {2'd2, 1'b1, 1'b0, 11'h0DC, 1'b1, 4'b0000}) begin
      errors++;
      $display("FAIL single_issue: got grant=%0d en=%b we=%b addr=%h busy=%b rdy=%b expected 2 1 0 0dc 1 0000",
               grant_id, bram_en, bram_we, bram_addr, busy, cpu_memory_ready);
    end
    tick();
    checks++;
    if ({bram_en, cpu_memory_ready} !== 5'b0_0000) begin
      errors++;
      $display("FAIL single_wait: got en=%b rdy=%b expected 0 0000", bram_en, cpu_memory_ready);
    end
    tick();
    checks++;
    if (cpu_memory_ready !== 4'b0100 || cpu_memory_data !== 20'h30041) begin
      errors++;
      $display("FAIL single_ready: got rdy=%b data=%h expected 0100 30041", cpu_memory_ready, cpu_memory_data);
    end
    set_cpu(2, 1'b0, 11'h0);
    tick();
    checks++;
    if (cpu_memory_ready !== 4'b0000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_done: got rdy=%b busy=%b expected 0000 0", cpu_memory_ready, busy);
    end
    tick();
    checks++;
    if (cpu_memory_data !== 20'h30041 || cpu_memory_ready !== 4'b0000) begin
      errors++;
      $display("FAIL single_hold: got data=%h rdy=%b expected 30041 0000", cpu_memory_data, cpu_memory_ready);
    end
  endtask

  task automatic test_round_robin();
    logic [19:0] words [4];
    logic [3:0]  exp_rdy;
    int          n;
    words[0] = 20'h11111; words[1] = 20'h22222; words[2] = 20'h33333; words[3] = 20'h44444;
    do_reset();
    set_cpu(0, 1'b1, 11'h011);
    set_cpu(1, 1'b1, 11'h122);
    set_cpu(2, 1'b1, 11'h233);
    set_cpu(3, 1'b1, 11'h344);
    for (int t = 1; t <= 15; t++) begin
      tick();
      n = (t / 3 - 1) % 4;
      exp_rdy = (t % 3 == 0) ? 4'(1 << n) : 4'b0000;
      checks++;
      if (cpu_memory_ready !== exp_rdy) begin
        errors++;
        $display("FAIL rr_ready t=%0d: got %b expected %b", t, cpu_memory_ready, exp_rdy);
      end
      if (t % 3 == 0) begin
        checks++;
        if (cpu_memory_data !== words[n] || grant_id !== 2'(n)) begin
          errors++;
          $display("FAIL rr_data t=%0d: got data=%h grant=%0d expected %h %0d",
                   t, cpu_memory_data, grant_id, words[n], n);
        end
      end
    end
    cpu_memory_valid = '0;
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL rr_drain: got busy=%b expected 0", busy);
    end
  endtask

  task automatic test_host_alternation();
    logic       exp_hwr;
    logic [3:0] exp_rdy;
    int         n;
    do_reset();
    host_write_valid = 1'b1;
    host_write_addr  = 11'h100;
    host_write_data  = 20'hF0100;
    set_cpu(1, 1'b1, 11'h100);
    for (int t = 1; t <= 20; t++) begin
      tick();
      exp_hwr = (t % 5 == 2);
      exp_rdy = (t % 5 == 0) ? 4'b0010 : 4'b0000;
      checks++;
      if (host_write_ready !== exp_hwr || cpu_memory_ready !== exp_rdy) begin
        errors++;
        $display("FAIL alt_pulses t=%0d: got hwr=%b rdy=%b expected %b %b",
                 t, host_write_ready, cpu_memory_ready, exp_hwr, exp_rdy);
      end
      if (t % 5 == 1 && t <= 16) begin
        checks++;
        if (bram_en !== 1'b1 || bram_we !== 1'b1 || bram_addr !== 11'(11'h100 + t / 5)) begin
          errors++;
          $display("FAIL alt_write t=%0d: got en=%b we=%b addr=%h expected 1 1 %h",
                   t, bram_en, bram_we, bram_addr, 11'(11'h100 + t / 5));
        end
      end
      if (t % 5 == 0) begin
        checks++;
        if (cpu_memory_data !== 20'hF0100) begin
          errors++;
          $display("FAIL alt_read t=%0d: got %h expected f0100", t, cpu_memory_data);
        end
      end
      if (exp_hwr) begin
        n = t / 5 + 1;
        if (n < 4) begin
          host_write_addr = 11'(11'h100 + n);
          host_write_data = 20'(20'hF0100 + n);
        end else begin
          host_write_valid = 1'b0;
        end
      end
    end
    set_cpu(1, 1'b0, 11'h0);
    tick();
    checks++;
    if (busy !== 1'b0 || host_write_ready !== 1'b0) begin
      errors++;
      $display("FAIL alt_drain: got busy=%b hwr=%b expected 0 0", busy, host_write_ready);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (mem[11'h100 + i] !== 20'(20'hF0100 + i)) begin
        errors++;
        $display("FAIL alt_mem[%0d]: got %h expected %h", i, mem[11'h100 + i], 20'(20'hF0100 + i));
      end
    end
  endtask

  task automatic test_late_change();
    set_cpu(0, 1'b1, 11'h010);
    tick();
    checks++;
    if (bram_addr !== 11'h010 || grant_id !== 2'd0 || bram_en !== 1'b1) begin
      errors++;
      $display("FAIL late_grant: got addr=%h grant=%0d en=%b expected 010 0 1", bram_addr, grant_id, bram_en);
    end
    set_cpu(0, 1'b1, 11'h020);
    tick();
    tick();
    checks++;
    if (cpu_memory_ready !== 4'b0001 || cpu_memory_data !== 20'hABCDE) begin
      errors++;
      $display("FAIL late_first: got rdy=%b data=%h expected 0001 abcde", cpu_memory_ready, cpu_memory_data);
    end
    tick();
    checks++;
    if (bram_en !== 1'b1 || bram_addr !== 11'h020 || cpu_memory_ready !== 4'b0000) begin
      errors++;
      $display("FAIL late_reissue: got en=%b addr=%h rdy=%b expected 1 020 0000", bram_en, bram_addr, cpu_memory_ready);
    end
    tick();
    tick();
    checks++;
    if (cpu_memory_ready !== 4'b0001 || cpu_memory_data !== 20'h12345) begin
      errors++;
      $display("FAIL late_second: got rdy=%b data=%h expected 0001 12345", cpu_memory_ready, cpu_memory_data);
    end
    set_cpu(0, 1'b0, 11'h0);
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL late_done: got busy=%b expected 0", busy);
    end
  endtask

  task automatic test_reset_mid_read();
    set_cpu(1, 1'b1, 11'h055);
    tick();
    tick();
    tick();
    checks++;
    if (cpu_memory_ready !== 4'b0010 || cpu_memory_data !== 20'h55555) begin
      errors++;
      $display("FAIL mid_pre: got rdy=%b data=%h expected 0010 55555", cpu_memory_ready, cpu_memory_data);
    end
    set_cpu(1, 1'b0, 11'h0);
    set_cpu(2, 1'b1, 11'h066);
    tick();
    checks++;
    if (grant_id !== 2'd2 || bram_addr !== 11'h066) begin
      errors++;
      $display("FAIL mid_grant: got grant=%0d addr=%h expected 2 066", grant_id, bram_addr);
    end
    tick();
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({cpu_memory_ready, host_write_ready, bram_en, bram_we, busy} !== 8'h00) begin
      errors++;
      $display("FAIL mid_async_ctrl: got %h expected 00",
               {cpu_memory_ready, host_write_ready, bram_en, bram_we, busy});
    end
    checks++;
    if ({cpu_memory_data, bram_addr, bram_wdata, grant_id} !== 53'h0) begin
      errors++;
      $display("FAIL mid_async_data: got %h expected 0",
               {cpu_memory_data, bram_addr, bram_wdata, grant_id});
    end
    set_cpu(2, 1'b0, 11'h0);
    tick();
    checks++;
    if (cpu_memory_ready !== 4'b0000 || cpu_memory_data !== 20'h0) begin
      errors++;
      $display("FAIL mid_no_pulse: got rdy=%b data=%h expected 0000 00000", cpu_memory_ready, cpu_memory_data);
    end
    rst = 1'b1;
    set_cpu(1, 1'b1, 11'h077);
    set_cpu(3, 1'b1, 11'h088);
    tick();
    checks++;
    if (grant_id !== 2'd1) begin
      errors++;
      $display("FAIL mid_rr_restart: got grant=%0d expected 1", grant_id);
    end
    tick();
    tick();
    checks++;
    if (cpu_memory_ready !== 4'b0010 || cpu_memory_data !== 20'h77777) begin
      errors++;
      $display("FAIL mid_cpu1: got rdy=%b data=%h expected 0010 77777", cpu_memory_ready, cpu_memory_data);
    end
    set_cpu(1, 1'b0, 11'h0);
    tick();
    checks++;
    if (grant_id !== 2'd3) begin
      errors++;
      $display("FAIL mid_cpu3_grant: got grant=%0d expected 3", grant_id);
    end
    tick();
    tick();
    checks++;
    if (cpu_memory_ready !== 4'b1000 || cpu_memory_data !== 20'h88888) begin
      errors++;
      $display("FAIL mid_cpu3: got rdy=%b data=%h expected 1000 88888", cpu_memory_ready, cpu_memory_data);
    end
    set_cpu(3, 1'b0, 11'h0);
    tick();
  endtask

  task automatic test_idle();
    for (int t = 0; t < 20; t++) begin
      tick();
      checks++;
      if ({cpu_memory_ready, host_write_ready, bram_en, busy} !== 7'h00) begin
        errors++;
        $display("FAIL idle t=%0d: got rdy=%b hwr=%b en=%b busy=%b expected all 0",
                 t, cpu_memory_ready, host_write_ready, bram_en, busy);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_round_robin();
    test_host_alternation();
    test_late_change();
    test_reset_mid_read();
    test_idle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
